// File: rtl/dataflow_deadlock_pkg.sv
// dataflow_deadlock_pkg: default sizing for the deadlock monitor and the AXI-stream owner idle-bit index helper.
package dataflow_deadlock_pkg;
  localparam int NUM_INST = 5;
  localparam int NUM_AXIS = 2;
  localparam int PERSIST_CYCLES = 4;
  function automatic int axis_idle_idx(input int k, input int which, input int n_inst = NUM_INST);
    return n_inst + 1 + 2 * k + which;
  endfunction
endpackage

// File: rtl/deadlock_persist_counter.sv
// deadlock_persist_counter: saturating consecutive-cycle counter turning cand into a registered block flag.
// Define DEADLOCK_STICKY_EN to hold block high until reset once it asserts.
module deadlock_persist_counter #(
  parameter int PERSIST_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic cand,
  output logic block
);
  localparam int W = $clog2(PERSIST_CYCLES + 1);
  localparam logic [W-1:0] MAX = W'(PERSIST_CYCLES);
  logic [W-1:0] cnt, cnt_nxt;
  logic block_nxt;
  always_comb begin
`ifdef DEADLOCK_STICKY_EN
    cnt_nxt = block ? cnt : !cand ? '0 : (cnt == MAX) ? cnt : cnt + 1'b1;
    block_nxt = block | (cnt_nxt == MAX);
`else
    cnt_nxt = !cand ? '0 : (cnt == MAX) ? cnt : cnt + 1'b1;
    block_nxt = cnt_nxt == MAX;
`endif
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      block <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      block <= block_nxt;
    end
  end
endmodule

// File: rtl/dataflow_deadlock_monitor.sv
// dataflow_deadlock_monitor: flags a dataflow region whose non-idle processes are all stalled on internal channels.
// Optional DEADLOCK_STICKY_EN makes the flag hold until reset (implemented in deadlock_persist_counter).
module dataflow_deadlock_monitor
  import dataflow_deadlock_pkg::*;
#(
  parameter int NUM_INST = dataflow_deadlock_pkg::NUM_INST,
  parameter int NUM_AXIS = dataflow_deadlock_pkg::NUM_AXIS,
  parameter int NUM_IDLE = NUM_INST + 1 + 2 * NUM_AXIS,
  parameter int PERSIST_CYCLES = dataflow_deadlock_pkg::PERSIST_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_IDLE-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  output logic                block
);
  logic [NUM_INST-1:0] idle;
  logic all_stuck, any_blocked, ext_wait, region_idle, cand;
  assign idle = inst_idle_sigs[NUM_INST-1:0];
  assign all_stuck = &(idle | inst_block_sigs);
  assign any_blocked = |(~idle & inst_block_sigs);
  assign region_idle = inst_idle_sigs[NUM_INST];
  // A wait on an AXI stream only counts while both owning processes are live.
  always_comb begin
    ext_wait = 1'b0;
    for (int k = 0; k < NUM_AXIS; k++)
      ext_wait = ext_wait | (axis_block_sigs[k] & ~inst_idle_sigs[axis_idle_idx(k, 0, NUM_INST)]
                                                & ~inst_idle_sigs[axis_idle_idx(k, 1, NUM_INST)]);
  end
  assign cand = all_stuck & any_blocked & ~ext_wait & ~region_idle;
  deadlock_persist_counter #(.PERSIST_CYCLES(PERSIST_CYCLES)) u_persist (
    .clock(clock),
    .reset(reset),
    .cand(cand),
    .block(block)
  );
endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// tb_dataflow_deadlock_monitor: directed and randomized checks of the deadlock monitor against a run-length model.
module tb_dataflow_deadlock_monitor;
  localparam int P = 4;
`ifdef DEADLOCK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] axis_s = '0;
  logic [9:0] idle_s = '0;
  logic [4:0] blk_s = '0;
  logic block;
  int checks = 0;
  int errors = 0;
  int run = 0;
  bit exp_block = 1'b0;

  dataflow_deadlock_monitor dut (
    .clock(clock),
    .reset(reset),
    .axis_block_sigs(axis_s),
    .inst_idle_sigs(idle_s),
    .inst_block_sigs(blk_s),
    .block(block)
  );

  always #5 clock = ~clock;

  function automatic bit model_cand(input logic [9:0] i, input logic [4:0] b, input logic [1:0] a);
    int stuck = 0;
    int blocked = 0;
    bit ext = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (i[p] || b[p]) stuck++;
      if (!i[p] && b[p]) blocked++;
    end
    for (int k = 0; k < 2; k++)
      if (a[k] && !i[6 + 2 * k] && !i[7 + 2 * k]) ext = 1'b1;
    return stuck == 5 && blocked > 0 && !ext && !i[5];
  endfunction

  // Model: block is set once the current run of consecutive candidate edges reaches P.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      run <= 0;
      exp_block <= 1'b0;
    end else if (!(STICKY && exp_block)) begin
      run <= model_cand(idle_s, blk_s, axis_s) ? run + 1 : 0;
      exp_block <= model_cand(idle_s, blk_s, axis_s) ? (run + 1 >= P) : 1'b0;
    end
  end

  always @(negedge clock) begin
    checks++;
    if (block !== exp_block) begin
      errors++;
      $display("FAIL model_cmp t=%0t: block=%b expected %b (idle=%b blk=%b axis=%b)",
               $time, block, exp_block, idle_s, blk_s, axis_s);
    end
  end

  task automatic chk(input logic exp, input string name);
    checks++;
    if (block !== exp) begin
      errors++;
      $display("FAIL %s: block=%b expected %b", name, block, exp);
    end
  endtask

  task automatic apply(input logic [9:0] i, input logic [4:0] b, input logic [1:0] a);
    idle_s = i;
    blk_s = b;
    axis_s = a;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk(1'b0, "reset_async");
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    chk(1'b0, "reset_state");
    // full stall: rises on 4th edge, falls one edge after a process resumes
    apply(10'b0, 5'b11111, 2'b00);
    tick(3); chk(1'b0, "stall_3");
    tick(1); chk(1'b1, "stall_4");
    apply(10'b0, 5'b11011, 2'b00);
    tick(1); chk(STICKY, "stall_drop");
    pulse_reset();
    // external wait masks the stall until its sub-pipeline goes idle
    apply(10'b0, 5'b11111, 2'b01);
    tick(6); chk(1'b0, "axis_wait");
    apply(10'b0010000000, 5'b11111, 2'b01);
    tick(3); chk(1'b0, "axis_stale_3");
    tick(1); chk(1'b1, "axis_stale_4");
    pulse_reset();
    apply(10'b0000011111, 5'b00000, 2'b00);
    tick(6); chk(1'b0, "all_idle");
    apply(10'b0000100000, 5'b11111, 2'b00);
    tick(6); chk(1'b0, "region_idle");
    pulse_reset();
    apply(10'b0000000101, 5'b11010, 2'b00);
    tick(4); chk(1'b1, "mixed_4");
    apply(10'b0000000101, 5'b10010, 2'b00);
    tick(1); chk(STICKY, "mixed_run_1");
    tick(3); chk(STICKY, "mixed_run_4");
    pulse_reset();
    // reset mid-count restarts detection
    apply(10'b0, 5'b11111, 2'b00);
    tick(3); chk(1'b0, "midcnt_3");
    pulse_reset();
    tick(3); chk(1'b0, "after_rst_3");
    tick(1); chk(1'b1, "after_rst_4");
    apply(10'b0, 5'b00000, 2'b00);
    tick(5); chk(STICKY, "cand_clear");
    pulse_reset();
    chk(1'b0, "post_reset");
    // randomized phase: hold each pattern a few cycles so the counter can saturate
    for (int n = 0; n < 600; n++) begin
      logic [9:0] i;
      logic [4:0] b;
      i = '0;
      b = '0;
      for (int p = 0; p < 5; p++) begin
        int r;
        r = $urandom_range(0, 9);
        i[p] = r < 3;
        b[p] = (r < 3) ? 1'($urandom_range(0, 1)) : (r < 9);
      end
      i[5] = $urandom_range(0, 7) == 0;
      for (int q = 6; q < 10; q++) i[q] = $urandom_range(0, 2) == 0;
      apply(i, b, ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
      if ($urandom_range(0, 39) == 0) pulse_reset();
      tick($urandom_range(1, 8));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
